// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, index/word types and the hardwired zero register index
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: write-back select between memory result and ALU result
module wb_mux #(
  parameter int W = 32
) (
  input  logic         memtoreg_in,
  input  logic [W-1:0] memres_in,
  input  logic [W-1:0] alures_in,
  output logic [W-1:0] wb_data
);
  assign wb_data = memtoreg_in ? memres_in : alures_in;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage and 32x32 register file; WB_BYPASS_EN forwards the committing write to the read ports
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [DATA_W-1:0] memres_in,
  input  logic [DATA_W-1:0] alures_in,
  input  logic [ADDR_W-1:0] writeregister_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  wb_mux #(.W(DATA_W)) u_mux (
    .memtoreg_in(memtoreg_in),
    .memres_in  (memres_in),
    .alures_in  (alures_in),
    .wb_data    (wb_data)
  );
  assign wb_en  = regwrite_in && (writeregister_in != ADDR_W'(ZERO_REG));
  assign wb_reg = writeregister_in;
  // commit write-back data; r0 is never written so it always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else if (wb_en) regs_q[writeregister_in] <= wb_data;
  end
`ifdef WB_BYPASS_EN
  logic rs_fwd, rt_fwd;
  assign rs_fwd = rst_n && wb_en && (rs_addr == writeregister_in);
  assign rt_fwd = rst_n && wb_en && (rt_addr == writeregister_in);
`else
  logic rs_fwd, rt_fwd;
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
`endif
  // combinational read ports, optionally forwarding the value being committed
  always_comb begin
    rs_data = rs_fwd ? wb_data : regs_q[rs_addr];
    rt_data = rt_fwd ? wb_data : regs_q[rt_addr];
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed checks of wb_regfile against an array model
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regwrite_in, memtoreg_in;
  logic [31:0] memres_in, alures_in;
  logic [4:0]  writeregister_in, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] model [32];
  int          n_chk = 0;
  int          n_fail = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memres_in(memres_in), .alures_in(alures_in), .writeregister_in(writeregister_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sel_data();
    return memtoreg_in ? memres_in : alures_in;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (regwrite_in && writeregister_in == a) return sel_data();
`endif
    return model[a];
  endfunction

  task automatic drive(input logic we, input logic mtr, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
    regwrite_in = we; memtoreg_in = mtr; memres_in = mem; alures_in = alu;
    writeregister_in = wr; rs_addr = rs; rt_addr = rt;
  endtask

  task automatic check_comb();
    check("wb_en", 32'(wb_en), 32'(regwrite_in && writeregister_in != 5'd0));
    check("wb_reg", 32'(wb_reg), 32'(writeregister_in));
    check("wb_data", wb_data, sel_data());
    check("rs_data", rs_data, exp_rd(rs_addr));
    check("rt_data", rt_data, exp_rd(rt_addr));
  endtask

  task automatic cyc();
    #1 check_comb();
    @(posedge clk);
    if (rst_n && regwrite_in && writeregister_in != 5'd0) model[writeregister_in] = sel_data();
    @(negedge clk);
  endtask

  initial begin
    model = '{default: 32'd0};
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check("reset_rs", rs_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 32'h1234, 32'hFFFF, 8, 8, 8); cyc();
    drive(1, 0, 32'h1234, 32'hFFFF, 8, 8, 8); cyc();
    drive(0, 0, 0, 0, 3, 8, 0); cyc();
    check("r8_alu", rs_data, 32'hFFFF);
    drive(1, 0, 0, 32'hAAAA5555, 0, 0, 0); cyc();
    drive(0, 0, 0, 32'd7, 3, 3, 0); cyc();
    drive(1, 0, 0, 32'd1, 9, 9, 9); cyc();
    drive(1, 0, 0, 32'd2, 9, 9, 9); cyc();
    drive(0, 0, 0, 0, 0, 9, 9); cyc();
    drive(1, 0, 0, 32'd10, 1, 0, 0); cyc();
    drive(1, 0, 0, 32'd20, 2, 1, 0); cyc();
    drive(1, 1, 32'h80000000, 0, 31, 2, 1); cyc();
    drive(0, 0, 0, 0, 0, 31, 2); cyc();
    drive(1, 0, 0, 32'hDEADBEEF, 5, 5, 5); cyc();
    drive(0, 0, 0, 0, 0, 5, 5);
    #1 check("r5_pre_rst", rs_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    model = '{default: 32'd0};
    #1 check("r5_async_rst", rs_data, 32'd0);
    drive(1, 0, 0, 32'h1111, 6, 6, 5); cyc();
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 5'(i), 5'(i));
      #1 check("post_rst_clear", rs_data, 32'd0);
    end
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, wr,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom), 5'($urandom));
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. The block takes the MEM/WB pipeline register outputs and selects the write-back data: memory result or ALU result. It commits that data to a 32×32 register file on the clock edge. It also serves the two combinational read ports used by the ID stage, and exposes the committed write for the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count; must equal 2**ADDR_W

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- regwrite_in  in  1  write enable from MEM/WB
- memtoreg_in  in  1  1 = write memres_in, 0 = write alures_in
- memres_in  in  DATA_W  memory read result from MEM/WB
- alures_in  in  DATA_W  ALU result from MEM/WB
- writeregister_in  in  ADDR_W  destination register index
- rs_addr  in  ADDR_W  read port A index (ID stage)
- rt_addr  in  ADDR_W  read port B index (ID stage)
- rs_data  out  DATA_W  read port A data
- rt_data  out  DATA_W  read port B data
- wb_en  out  1  effective write this cycle: regwrite_in and writeregister_in != 0
- wb_reg  out  ADDR_W  writeregister_in, passed through
- wb_data  out  DATA_W  selected write-back data, combinational

## Operation
- Write-back mux: wb_data = memtoreg_in ? memres_in : alures_in. This is combinational and active regardless of regwrite_in.
- Write: on a rising clk edge with rst_n high and wb_en = 1, regs[writeregister_in] takes wb_data.
- Register 0 is hardwired to 0. Writes to it are discarded and wb_en is 0 for them. Reads of index 0 return 0 in every configuration.
- Reads are combinational: rs_data = regs[rs_addr] and rt_data = regs[rt_addr]. Both ports may address the same register.
- Reset: while rst_n is low, all registers clear to 0 immediately and asynchronously, and writes are blocked.
  - rs_data and rt_data read 0 during reset.
  - wb_en, wb_reg and wb_data stay combinational functions of their inputs during reset.
- Reset asserted mid-operation:
  - A write whose edge coincides with rst_n low is lost.
  - The first write after rst_n deasserts lands on the first rising edge with rst_n high.
- No handshake and no stall: the block commits every cycle that wb_en is 1.

## Timing
- Write latency is one edge. Data written at edge N is visible on the read ports from just after edge N.
- Same-cycle write and read of the same nonzero register, without bypass: the read returns the old value.
- Read path: address to data is combinational. There is no output register.
- wb_en, wb_reg and wb_data are zero-latency combinational outputs.

## Configuration
- WB_BYPASS_EN defined:
  - When wb_en = 1 and rs_addr (or rt_addr) equals writeregister_in, that port returns wb_data in the same cycle.
  - This removes the write-first/read-second half-cycle hazard, so the ID stage sees the value being committed.
  - Bypass is suppressed for index 0 and while rst_n is low.
- WB_BYPASS_EN undefined: reads always return stored register contents, per the "without bypass" rule under Timing.

## Structure
- Shared package pipeline_pkg holds:
  - DATA_W, ADDR_W and NUM_REGS constants
  - the reg_idx_t typedef (ADDR_W bits) and the word_t typedef (DATA_W bits)
  - the ZERO_REG constant (index 0)
- One sub-module, wb_mux: the 2:1 write-back select producing wb_data.
- Register array, write logic, read ports and optional bypass all live in wb_regfile.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low mid-cycle -> rs_addr=5 reads 0 immediately; all 31 registers read 0 after release.
- Mux select: regwrite_in=1, writeregister_in=8, memtoreg_in=1, memres_in=0x1234, alures_in=0xFFFF -> after edge, r8=0x1234. Repeat with memtoreg_in=0 -> r8=0xFFFF.
- Zero register: regwrite_in=1, writeregister_in=0, alures_in=0xAAAA5555 -> wb_en=0; r0 reads 0 on both ports.
- Write disabled: regwrite_in=0, writeregister_in=3, alures_in=7 -> r3 unchanged; wb_en=0; wb_data=7.
- Same-cycle read/write: r9=1, then write r9←2 while rs_addr=rt_addr=9 -> before the edge, ports read 1 without WB_BYPASS_EN and 2 with it; after the edge, both configurations read 2.
- Back-to-back: writes r1←10, r2←20, r31←0x80000000 on consecutive edges -> each is readable the cycle after its edge; r31 reads exactly 0x80000000.
